// File: rtl/puc_pkg.sv
// puc_pkg: shared types and constants for the PUC CPU call/return path.
package puc_pkg;

   typedef enum logic {
      OVF_WRAP,
      OVF_SATURATE
   } ovf_mode_t;

   localparam int PC_W_DEFAULT = 16;

   // Decoder opcodes that drive call/ret/flush of the return stack.
   localparam logic [3:0] OPC_CALL  = 4'hC;
   localparam logic [3:0] OPC_RET   = 4'hD;
   localparam logic [3:0] OPC_RESET = 4'hF;

endpackage

// File: rtl/return_stack_mem.sv
// return_stack_mem: DEPTH x PC_WIDTH register file, one sync write port, one async read port.
module return_stack_mem #(
   parameter int PC_WIDTH = 16,
   parameter int DEPTH    = 16,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic                clock,
   input  logic                we,
   input  logic [AW-1:0]       waddr,
   input  logic [PC_WIDTH-1:0] wdata,
   input  logic [AW-1:0]       raddr,
   output logic [PC_WIDTH-1:0] rdata
);

   logic [PC_WIDTH-1:0] mem_q [DEPTH];
   logic [PC_WIDTH-1:0] mem_d [DEPTH];

   always_comb begin
      mem_d = mem_q;
      if (we) mem_d[waddr] = wdata;
   end

   always_ff @(posedge clock) mem_q <= mem_d;

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/return_stack.sv
// return_stack: return-address stack with configurable depth, overflow policy,
// simultaneous call/return, flush, occupancy and sticky error flags.
module return_stack
   import puc_pkg::*;
#(
   parameter int        PC_WIDTH = PC_W_DEFAULT,
   parameter int        DEPTH    = 16,
   parameter ovf_mode_t OVF_MODE = OVF_WRAP,
   localparam int       AW       = $clog2(DEPTH),
   localparam int       CW       = $clog2(DEPTH + 1)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                call,
   input  logic                ret,
   input  logic                flush,
   input  logic                err_clear,
   input  logic [PC_WIDTH-1:0] called_from,
   output logic [PC_WIDTH-1:0] return_to,
   output logic [CW-1:0]       count,
   output logic                empty,
   output logic                full,
   output logic                overflow,
   output logic                underflow
);

   localparam logic [AW-1:0] LAST     = AW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [AW-1:0]       wp_q, wp_d, wp_inc, wp_dec, waddr;
   logic [CW-1:0]       count_q, count_d;
   logic                ovf_q, ovf_d, unf_q, unf_d;
   logic                we;
   logic [PC_WIDTH-1:0] wdata, rdata;

   // Explicit compare-to-limit so non-power-of-two depths wrap correctly.
   assign wp_inc = (wp_q == LAST) ? '0 : wp_q + AW'(1);
   assign wp_dec = (wp_q == '0) ? LAST : wp_q - AW'(1);

   assign empty = (count_q == '0);
   assign full  = (count_q == FULL_CNT);
   assign wdata = called_from + PC_WIDTH'(1);

   always_comb begin
      wp_d    = wp_q;
      count_d = count_q;
      ovf_d   = ovf_q & ~err_clear;
      unf_d   = unf_q & ~err_clear;
      we      = 1'b0;
      waddr   = wp_q;
      if (flush) begin
         wp_d    = '0;
         count_d = '0;
      end else if (call && ret) begin
         we = 1'b1;
         if (!empty) begin
            waddr = wp_dec;
         end else begin
            wp_d    = wp_inc;
            count_d = CW'(1);
            unf_d   = 1'b1;
         end
      end else if (call) begin
         if (!full) begin
            we      = 1'b1;
            wp_d    = wp_inc;
            count_d = count_q + CW'(1);
         end else begin
            ovf_d = 1'b1;
            if (OVF_MODE == OVF_WRAP) begin
               we   = 1'b1;
               wp_d = wp_inc;
            end
         end
      end else if (ret) begin
         if (!empty) begin
            wp_d    = wp_dec;
            count_d = count_q - CW'(1);
         end else begin
            unf_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wp_q    <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         wp_q    <= wp_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   return_stack_mem #(.PC_WIDTH(PC_WIDTH), .DEPTH(DEPTH)) u_mem (
      .clock (clock),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .raddr (wp_dec),
      .rdata (rdata)
   );

   // Gating hides unreset storage contents whenever the stack is empty.
   assign return_to = empty ? '0 : rdata;
   assign count     = count_q;
   assign overflow  = ovf_q;
   assign underflow = unf_q;

endmodule
